// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared state type and modulo-N index helpers for the round-robin arbiter
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    BUSY  = 2'd2
  } arb_state_t;

  // Next index after v in a ring of n slots.
  function automatic int wrap_inc(input int v, input int n);
    return (v >= n - 1) ? 0 : v + 1;
  endfunction

  // Folds a position from the doubled scan window back into 0..n-1.
  function automatic int fold_index(input int pos, input int n);
    return (pos >= n) ? pos - n : pos;
  endfunction

endpackage

// File: rtl/decoder.sv
// rtl/decoder.sv - binary index to one-hot select vector
module decoder #(
  parameter int N     = 16,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [IDX_W-1:0] binary,
  output logic [N-1:0]     one_hot
);

  always_comb begin
    one_hot = '0;
    for (int i = 0; i < N; i++) begin
      one_hot[i] = (int'(binary) == i);
    end
  end

endmodule

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first set request at or after ptr, wrapping
module rr_pick
  import arb_pkg::*;
#(
  parameter int N     = 16,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [N-1:0]   masked;
  logic [2*N-1:0] dbl;
  int             pos;

  // Lower half holds requests at or above ptr; upper half is the wrapped copy,
  // so the lowest set bit of dbl is the round-robin winner.
  always_comb begin
    masked = '0;
    for (int i = 0; i < N; i++) begin
      masked[i] = req[i] && (i >= int'(ptr));
    end
    dbl = {req, masked};
    pos = 0;
    for (int i = 2 * N - 1; i >= 0; i--) begin
      if (dbl[i]) pos = i;
    end
    any = |req;
    idx = IDX_W'(fold_index(pos, N));
  end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter offering a grant over valid/ready and holding it until release
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 grant_ready,
  input  logic                 grant_release,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 busy
);

  localparam int IDX_W = $clog2(N);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic             valid_nxt, busy_nxt;
  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;

  rr_pick #(
    .N    (N),
    .IDX_W(IDX_W)
  ) u_pick (
    .req(req),
    .ptr(ptr),
    .any(pick_any),
    .idx(pick_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      grant_valid <= valid_nxt;
      grant_idx   <= idx_nxt;
      busy        <= busy_nxt;
    end
  end

  // Outputs are computed one cycle ahead so every output leaves a flop.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    valid_nxt = grant_valid;
    idx_nxt   = grant_idx;
    busy_nxt  = busy;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt = OFFER;
          valid_nxt = 1'b1;
          idx_nxt   = pick_idx;
        end
      end
      OFFER: begin
        if (grant_ready) begin
          state_nxt = BUSY;
          valid_nxt = 1'b0;
          busy_nxt  = 1'b1;
        end
      end
      BUSY: begin
        if (grant_release) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          ptr_nxt   = IDX_W'(wrap_inc(int'(grant_idx), N));
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - randomized and directed check of rr_arbiter plus decoder against a transaction model
module tb_rr_arbiter;

  localparam int N     = 16;
  localparam int IDX_W = $clog2(N);

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req;
  logic             grant_ready;
  logic             grant_release;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
  logic             busy;
  logic [N-1:0]     one_hot;

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0=waiting, 1=offering, 2=owned.
  int m_phase, m_ptr, m_idx;
  bit m_valid, m_busy;

  always #5 clk = ~clk;

  rr_arbiter #(.N(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .grant_ready  (grant_ready),
    .grant_release(grant_release),
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx),
    .busy         (busy)
  );

  decoder #(.N(N)) u_dec (
    .binary (grant_idx),
    .one_hot(one_hot)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic [N-1:0] r, input bit rdy, input bit rel, input bit rn);
    if (!rn) begin
      m_phase = 0; m_ptr = 0; m_idx = 0; m_valid = 0; m_busy = 0;
    end else if (m_phase == 0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (r[c]) begin
          m_idx = c; m_valid = 1; m_phase = 1;
          break;
        end
      end
    end else if (m_phase == 1) begin
      if (rdy) begin
        m_valid = 0; m_busy = 1; m_phase = 2;
      end
    end else begin
      if (rel) begin
        m_busy = 0; m_phase = 0; m_ptr = (m_idx + 1) % N;
      end
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, then compare just after it.
  task automatic cyc(input logic [N-1:0] r, input bit rdy, input bit rel, input bit rn);
    req = r; grant_ready = rdy; grant_release = rel; rst_n = rn;
    @(posedge clk);
    model_edge(r, rdy, rel, rn);
    #1;
    check("grant_valid", 32'(grant_valid), 32'(m_valid));
    check("busy", 32'(busy), 32'(m_busy));
    check("grant_idx", 32'(grant_idx), 32'(m_idx));
    check("one_hot", 32'(one_hot), 32'(1) << m_idx);
  endtask

  initial begin
    req = '0; grant_ready = 0; grant_release = 0; rst_n = 0;

    // Reset with everything requesting.
    cyc(16'hFFFF, 1, 1, 0);
    cyc(16'hFFFF, 1, 1, 0);
    check("rst_one_hot", 32'(one_hot), 32'h0001);
    check("rst_valid", 32'(grant_valid), 32'd0);

    // Single request: offer 5, accept, release; next pick starts at 6.
    cyc(16'h0020, 1, 0, 1);
    check("single_idx", 32'(grant_idx), 32'd5);
    check("single_valid", 32'(grant_valid), 32'd1);
    cyc(16'h0020, 1, 0, 1);
    check("single_busy", 32'(busy), 32'd1);
    cyc(16'h0000, 0, 1, 1);
    cyc(16'hFFFF, 0, 0, 1);
    check("ptr_after_5", 32'(grant_idx), 32'd6);
    cyc(16'h0000, 0, 0, 0);

    // All requesting: strict rotation including the 15 -> 0 wrap.
    for (int i = 0; i <= N; i++) begin
      cyc(16'hFFFF, 1, 0, 1);
      check("rr_order", 32'(grant_idx), 32'(i % N));
      cyc(16'hFFFF, 1, 0, 1);
      cyc(16'hFFFF, 1, 1, 1);
    end

    // Stalled offer is held while req moves elsewhere.
    cyc(16'h0000, 0, 0, 0);
    cyc(16'h0008, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(16'h0100, 0, 0, 1);
      check("stall_idx", 32'(grant_idx), 32'd3);
      check("stall_valid", 32'(grant_valid), 32'd1);
    end
    cyc(16'h0100, 1, 0, 1);
    check("stall_busy_idx", 32'(grant_idx), 32'd3);
    check("stall_busy", 32'(busy), 32'd1);
    cyc(16'h0000, 0, 1, 1);

    // release and grant_ready in IDLE do nothing.
    cyc(16'h0000, 0, 1, 1);
    cyc(16'h0000, 1, 0, 1);
    check("idle_valid", 32'(grant_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_idx_kept", 32'(grant_idx), 32'd3);

    // Reset in the middle of an owned grant.
    cyc(16'h0000, 0, 0, 0);
    cyc(16'h0200, 0, 0, 1);
    cyc(16'h0200, 1, 0, 1);
    check("pre_rst_busy", 32'(busy), 32'd1);
    cyc(16'h0200, 1, 1, 0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_idx", 32'(grant_idx), 32'd0);
    cyc(16'h0200, 0, 0, 1);
    check("post_rst_idx", 32'(grant_idx), 32'd9);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] r;
      case ($urandom_range(0, 3))
        0: r = '0;
        1: r = N'(1) << $urandom_range(0, N - 1);
        2: r = N'($urandom) & N'($urandom);
        default: r = N'($urandom);
      endcase
      cyc(r, ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 63) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
